// File: rtl/gmii_test_frame_tx.sv
// Ethernet test-frame generator for a byte-wide GMII transmit interface.
// Each frame is preamble, SFD, a fixed header, a counting payload, zero pad up
// to the 46-byte minimum, and the FCS (CRC-32).
//
// All outputs are registered from the current state, so they trail the state
// register by one cycle. As a result, a start accepted at edge N shows up on
// the wire after edge N+1. Between frames the line carries the GAP cycles plus
// the one IDLE cycle with tx_en low.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; captures clamped length and seed
// PRE   | 7 bytes of 0x55
// SFD   | 1 byte of 0xD5
// HDR   | 14 header bytes (dst MAC, src MAC, EtherType), CRC'd
// PAY   | eff_len counting bytes seed, seed+1, ..., CRC'd
// PAD   | zero bytes up to 46 data bytes, CRC'd
// FCS   | 4 bytes of complemented CRC, least-significant byte first
// GAP   | ifg idle cycles; done and frame count bump on the last one

module gmii_test_frame_tx #(
  parameter logic [47:0] dst_mac   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] src_mac   = 48'h1234_5678_9ABC,
  parameter logic [15:0] ethertype = 16'h88B5,
  parameter int unsigned ifg       = 12,
  parameter int unsigned max_len   = 1500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] len,
  input  logic [7:0]  seed,
  output logic [7:0]  txd,
  output logic        tx_en,
  output logic        tx_er,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_HDR, S_PAY, S_PAD, S_FCS, S_GAP
  } state_t;

  localparam logic [111:0] HDR_BYTES = {dst_mac, src_mac, ethertype};
  localparam logic [15:0]  MAX_LEN16 = 16'(max_len);
  localparam logic [10:0]  MAX_LEN11 = 11'(max_len);
  localparam logic [10:0]  IFG_M1    = 11'(ifg - 1);
  localparam logic [10:0]  MIN_DATA  = 11'd46;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] eff_len_q, eff_len_d;
  logic [7:0]  pay_q, pay_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] fc_q, fc_d;

  logic [7:0]  data_byte;
  logic        tc;
  logic [6:0]  hdr_sh;
  logic [4:0]  fcs_sh;

  // Reflected CRC-32 (poly 0x04C11DB7 -> 0xEDB88320), one byte per call.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int b = 0; b < 8; b++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  // Terminal count and byte selectors derived from the down-counter.
  // HDR loads 13 and counts down, so cnt*8 addresses the header MSB-first;
  // FCS loads 3, so (3 - cnt)*8 walks the CRC from its low byte up.
  assign tc     = (cnt_q == 11'd0);
  assign hdr_sh = {cnt_q[3:0], 3'b000};
  assign fcs_sh = {2'd3 - cnt_q[1:0], 3'b000};

  // Next-state, counter, CRC and registered-output decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    eff_len_d = eff_len_q;
    pay_d     = pay_q;
    crc_d     = crc_q;
    fc_d      = fc_q;
    txd_d     = 8'h00;
    tx_en_d   = 1'b0;
    busy_d    = 1'b1;
    done_d    = 1'b0;
    data_byte = 8'h00;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d   = S_PRE;
          cnt_d     = 11'd6;
          eff_len_d = (len > MAX_LEN16) ? MAX_LEN11 : len[10:0];
          pay_d     = seed;
          crc_d     = 32'hFFFF_FFFF;
        end
      end

      S_PRE: begin
        tx_en_d = 1'b1;
        txd_d   = 8'h55;
        if (tc) begin
          state_d = S_SFD;
        end else begin
          cnt_d = cnt_q - 11'd1;
        end
      end

      S_SFD: begin
        tx_en_d = 1'b1;
        txd_d   = 8'hD5;
        state_d = S_HDR;
        cnt_d   = 11'd13;
      end

      S_HDR: begin
        data_byte = HDR_BYTES[hdr_sh +: 8];
        tx_en_d   = 1'b1;
        txd_d     = data_byte;
        crc_d     = crc32_byte(crc_q, data_byte);
        if (tc) begin
          if (eff_len_q != 11'd0) begin
            state_d = S_PAY;
            cnt_d   = eff_len_q - 11'd1;
          end else begin
            state_d = S_PAD;
            cnt_d   = MIN_DATA - 11'd1;
          end
        end else begin
          cnt_d = cnt_q - 11'd1;
        end
      end

      S_PAY: begin
        data_byte = pay_q;
        tx_en_d   = 1'b1;
        txd_d     = data_byte;
        crc_d     = crc32_byte(crc_q, data_byte);
        pay_d     = pay_q + 8'd1;
        if (tc) begin
          if (eff_len_q < MIN_DATA) begin
            state_d = S_PAD;
            cnt_d   = MIN_DATA - 11'd1 - eff_len_q;
          end else begin
            state_d = S_FCS;
            cnt_d   = 11'd3;
          end
        end else begin
          cnt_d = cnt_q - 11'd1;
        end
      end

      S_PAD: begin
        tx_en_d = 1'b1;
        txd_d   = data_byte;
        crc_d   = crc32_byte(crc_q, data_byte);
        if (tc) begin
          state_d = S_FCS;
          cnt_d   = 11'd3;
        end else begin
          cnt_d = cnt_q - 11'd1;
        end
      end

      S_FCS: begin
        // crc_q already holds every data byte; it stays frozen here.
        tx_en_d = 1'b1;
        txd_d   = ~crc_q[fcs_sh +: 8];
        if (tc) begin
          state_d = S_GAP;
          cnt_d   = IFG_M1;
        end else begin
          cnt_d = cnt_q - 11'd1;
        end
      end

      S_GAP: begin
        if (tc) begin
          done_d  = 1'b1;
          fc_d    = fc_q + 16'd1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 11'd1;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 11'd0;
      eff_len_q <= 11'd0;
      pay_q     <= 8'h00;
      crc_q     <= 32'hFFFF_FFFF;
      txd_q     <= 8'h00;
      tx_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fc_q      <= 16'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      eff_len_q <= eff_len_d;
      pay_q     <= pay_d;
      crc_q     <= crc_d;
      txd_q     <= txd_d;
      tx_en_q   <= tx_en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fc_q      <= fc_d;
    end
  end

  assign txd         = txd_q;
  assign tx_en       = tx_en_q;
  assign tx_er       = 1'b0;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_gmii_test_frame_tx.sv
// Directed bench for gmii_test_frame_tx: a table of single frames checked
// against a byte-level frame model, plus start-while-busy, back-to-back and
// mid-frame reset sequences.

module tb_gmii_test_frame_tx;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] len;
  logic [7:0]  seed;
  logic [7:0]  txd;
  logic        tx_en, tx_er, busy, done;
  logic [15:0] frame_count;

  gmii_test_frame_tx #(
    .dst_mac  (48'hFFFF_FFFF_FFFF),
    .src_mac  (48'h1234_5678_9ABC),
    .ethertype(16'h88B5),
    .ifg      (12),
    .max_len  (1500)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .seed       (seed),
    .txd        (txd),
    .tx_en      (tx_en),
    .tx_er      (tx_er),
    .busy       (busy),
    .done       (done),
    .frame_count(frame_count)
  );

  always #4 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] cap  [0:2047];
  logic [7:0] expb [0:2047];
  int cap_n, pre_low, er_hi, exp_n, exp_eff;

  typedef struct {
    logic [15:0] len;
    logic [7:0]  seed;
    int          txen_cycles;
  } vec_t;

  vec_t vecs [0:7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic build_expected(input logic [15:0] l, input logic [7:0] s);
    int body;
    logic [31:0]  crc;
    logic [111:0] hdr;
    logic [7:0]   pb;
    exp_eff = (l > 16'd1500) ? 1500 : int'(l);
    body    = 14 + ((exp_eff > 46) ? exp_eff : 46);
    for (int i = 0; i < 7; i++) expb[i] = 8'h55;
    expb[7] = 8'hD5;
    hdr = {48'hFFFF_FFFF_FFFF, 48'h1234_5678_9ABC, 16'h88B5};
    for (int i = 0; i < 14; i++) expb[8+i] = hdr[111-8*i -: 8];
    pb = s;
    for (int i = 0; i < exp_eff; i++) begin
      expb[22+i] = pb;
      pb = pb + 8'd1;
    end
    for (int i = exp_eff; i < body - 14; i++) expb[22+i] = 8'h00;
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < body; i++) crc = crc_step(crc, expb[8+i]);
    crc = ~crc;
    for (int i = 0; i < 4; i++) expb[8+body+i] = crc[8*i +: 8];
    exp_n = 8 + body + 4;
  endtask

  task automatic check_section(input string name, input int lo, input int hi);
    int bad;
    bad = -1;
    for (int i = lo; i < hi && i < cap_n; i++)
      if (bad < 0 && cap[i] !== expb[i]) bad = i;
    if (bad >= 0)                    chk(name, cap[bad], expb[bad]);
    else if (hi > lo && hi-1 < cap_n) chk(name, cap[hi-1], expb[hi-1]);
    else if (hi > lo)                chk({name, "_short"}, cap_n, hi);
  endtask

  task automatic check_frame(input logic [15:0] l, input logic [7:0] s, input int txen_cycles);
    build_expected(l, s);
    chk("txen_cycles", cap_n, txen_cycles);
    chk("tx_er_high", er_hi, 0);
    check_section("preamble_sfd", 0, 8);
    check_section("header", 8, 22);
    check_section("payload", 22, 22 + exp_eff);
    check_section("pad", 22 + exp_eff, exp_n - 4);
    check_section("fcs", exp_n - 4, exp_n);
  endtask

  task automatic launch(input logic [15:0] l, input logic [7:0] s);
    start = 1'b1;
    len   = l;
    seed  = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts low cycles up to the tx_en rise, then captures bytes until it falls.
  task automatic capture_frame(input bit drop_start);
    pre_low = 0;
    cap_n   = 0;
    er_hi   = 0;
    while (tx_en !== 1'b1 && pre_low < 200) begin
      pre_low++;
      @(negedge clk);
    end
    if (tx_en !== 1'b1) begin
      chk("txen_rise_timeout", tx_en, 1'b1);
      return;
    end
    if (drop_start) start = 1'b0;
    while (tx_en === 1'b1 && cap_n < 2000) begin
      cap[cap_n] = txd;
      if (tx_er !== 1'b0) er_hi++;
      cap_n++;
      @(negedge clk);
    end
  endtask

  // Entered on the first low cycle after a frame.
  task automatic gap_check(input logic [15:0] exp_fc);
    int n, bad;
    n   = 0;
    bad = 0;
    while (n < 300) begin
      n++;
      if (busy !== 1'b1 || tx_en !== 1'b0 || txd !== 8'h00) bad++;
      if (done === 1'b1) break;
      @(negedge clk);
    end
    chk("done_delay", n, 12);
    chk("gap_busy_idle_line", bad, 0);
    chk("frame_count", frame_count, exp_fc);
    @(negedge clk);
    chk("busy_after_done", busy, 1'b0);
    chk("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hi;

    vecs[0] = '{16'd0,    8'h00, 72};
    vecs[1] = '{16'd100,  8'hF0, 126};
    vecs[2] = '{16'd1600, 8'h5A, 1526};
    vecs[3] = '{16'd45,   8'hFF, 72};
    vecs[4] = '{16'd46,   8'h80, 72};
    vecs[5] = '{16'd47,   8'h01, 73};
    vecs[6] = '{16'd1500, 8'hC3, 1526};
    vecs[7] = '{16'd1,    8'h7E, 72};

    rst = 1'b1; start = 1'b0; len = 16'd0; seed = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 8'h00);
    chk("rst_tx_en", tx_en, 1'b0);
    chk("rst_tx_er", tx_er, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_frame_count", frame_count, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 8; k++) begin
      launch(vecs[k].len, vecs[k].seed);
      capture_frame(1'b0);
      chk("start_latency", pre_low, 1);
      check_frame(vecs[k].len, vecs[k].seed, vecs[k].txen_cycles);
      gap_check(16'(k + 1));
    end

    // Second start mid-payload is ignored.
    launch(16'd100, 8'h10);
    fork
      capture_frame(1'b0);
      begin
        repeat (60) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    check_frame(16'd100, 8'h10, 126);
    gap_check(16'd9);
    hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx_en === 1'b1) hi++;
    end
    chk("no_second_frame", hi, 0);

    // Back-to-back with start held high.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1; len = 16'd20; seed = 8'h40;
    for (int f = 0; f < 3; f++) begin
      capture_frame(f == 2);
      if (f > 0) chk("b2b_low_cycles", pre_low, 13);
      check_frame(16'd20, 8'h40, 72);
    end
    start = 1'b0;
    gap_check(16'd3);

    // Reset asserted while the header is on the wire.
    launch(16'd10, 8'hA5);
    hi = 0;
    while (tx_en !== 1'b1 && hi < 20) begin
      hi++;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("pre_rst_in_frame", tx_en, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_tx_en", tx_en, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_txd", txd, 8'h00);
    rst = 1'b0;
    hi = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_en === 1'b1) hi++;
    end
    chk("no_fcs_after_rst", hi, 0);
    launch(16'd10, 8'hA5);
    capture_frame(1'b0);
    chk("start_latency", pre_low, 1);
    check_frame(16'd10, 8'hA5, 72);
    gap_check(16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
